// File: rtl/arb_mux_pipe_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// No latency of its own; pure wiring.
// The mux drives in_ready and the out_* word; producers and the consumer drive the rest.
interface arb_mux_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
);
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]       in_valid;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbitrating mux side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux_pipe.sv
// N-channel arbitrating mux (fixed priority or round-robin) into a one-deep output register.
// One cycle latency, one word per cycle when the consumer is ready.
// When the held word is not taken, every in_ready drops and the output word and rr pointer hold.
module arb_mux_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int MODE  = 0
) (
  input  logic          clk,
  input  logic          reset,
  arb_mux_pipe_if.slave bus
);
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load;
  logic             g_any;
  logic [SEL_W-1:0] g_idx;
  logic [SEL_W-1:0] cand_idx;
  logic [N_IN-1:0]  grant;
  logic [WIDTH-1:0] win_data;

  // The output register can take a new word when it is empty or being drained this cycle
  assign load = !out_valid_q || bus.out_ready;

  // Pick the winning channel index from in_valid only, so in_ready never depends on in_data
  always_comb begin
    g_any    = 1'b0;
    g_idx    = '0;
    cand_idx = '0;
    if (MODE == 1) begin
      // Search starts just past the last winner and wraps at N_IN-1 -> 0
      for (int k = 1; k <= N_IN; k++) begin
        cand_idx = SEL_W'((int'(last_q) + k) % N_IN);
        if (!g_any && bus.in_valid[cand_idx]) begin
          g_any = 1'b1;
          g_idx = cand_idx;
        end
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (!g_any && bus.in_valid[i]) begin
          g_any = 1'b1;
          g_idx = SEL_W'(i);
        end
      end
    end
  end

  // One-hot grant and the matching data word
  always_comb begin
    grant    = '0;
    win_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      grant[i] = g_any && (g_idx == SEL_W'(i));
      if (grant[i]) begin
        win_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset is masked in so no channel sees a handshake while the block is held in reset
  assign bus.in_ready = (load && reset) ? grant : '0;

  // Next state of the output register and rr pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = g_any;
      if (g_any) begin
        out_data_d = win_data;
        out_sel_d  = g_idx;
        if (MODE == 1) begin
          last_d = g_idx;
        end
      end
    end
  end

  // State registers; async reset discards any held word immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_arb_mux_pipe.sv
// Directed bench: fixed-priority 4-way, round-robin 4-way and round-robin 3-way instances.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
// Stall and async reset cases are exercised on the round-robin 4-way instance.
module tb_arb_mux_pipe;
  logic clk;
  logic reset;

  int n_chk;
  int n_err;

  int exp_c[3] = '{0, 2, 0};

  arb_mux_pipe_if #(.WIDTH(32), .N_IN(4)) a_if ();
  arb_mux_pipe_if #(.WIDTH(32), .N_IN(4)) b_if ();
  arb_mux_pipe_if #(.WIDTH(32), .N_IN(3)) c_if ();

  arb_mux_pipe #(.WIDTH(32), .N_IN(4), .MODE(0)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  arb_mux_pipe #(.WIDTH(32), .N_IN(4), .MODE(1)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
  arb_mux_pipe #(.WIDTH(32), .N_IN(3), .MODE(1)) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // Reset with every channel requesting
    reset = 1'b0;
    a_if.in_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    b_if.in_data   = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    c_if.in_data   = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    a_if.in_valid  = 4'b1111;
    b_if.in_valid  = 4'b1111;
    c_if.in_valid  = 3'b111;
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    c_if.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_a_vld",   32'(a_if.out_valid), 32'd0);
    check("rst_a_sel",   32'(a_if.out_sel),   32'd0);
    check("rst_a_data",  a_if.out_data,       32'd0);
    check("rst_a_rdy",   32'(a_if.in_ready),  32'd0);
    check("rst_b_vld",   32'(b_if.out_valid), 32'd0);
    check("rst_b_rdy",   32'(b_if.in_ready),  32'd0);
    check("rst_c_rdy",   32'(c_if.in_ready),  32'd0);

    // Release: both 4-way instances grant ch0 first (rr pointer starts at 3)
    c_if.in_valid = 3'b000;
    reset = 1'b1;
    #1;
    check("rel_a_rdy", 32'(a_if.in_ready), 32'b0001);
    check("rel_b_rdy", 32'(b_if.in_ready), 32'b0001);
    check("rel_c_rdy", 32'(c_if.in_ready), 32'b000);

    // Round-robin over all four channels, fixed priority stays on ch0
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_b_vld",  32'(b_if.out_valid), 32'd1);
      check("rr_b_sel",  32'(b_if.out_sel),   32'(k % 4));
      check("rr_b_data", b_if.out_data,       32'hB000_0000 + 32'(k % 4));
      check("fp_a_sel",  32'(a_if.out_sel),   32'd0);
    end

    // Fixed priority with channels 1 and 3 requesting: ch1 every cycle
    a_if.in_valid = 4'b1010;
    b_if.in_valid = 4'b0000;
    #1;
    check("fp_a_rdy0", 32'(a_if.in_ready), 32'b0010);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_a_sel1",  32'(a_if.out_sel),  32'd1);
      check("fp_a_data1", a_if.out_data,      32'hA000_0001);
      check("fp_a_rdy",   32'(a_if.in_ready), 32'b0010);
    end

    // Three channels, pointer at 2, channels 0 and 2 requesting: 0, 2, 0
    c_if.in_valid = 3'b101;
    #1;
    check("wrap_c_rdy0", 32'(c_if.in_ready), 32'b001);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_c_vld",  32'(c_if.out_valid), 32'd1);
      check("wrap_c_sel",  32'(c_if.out_sel),   32'(exp_c[k]));
      check("wrap_c_data", c_if.out_data,       32'hC000_0000 + 32'(exp_c[k]));
    end
    c_if.in_valid = 3'b000;

    // Stall: load DEADBEEF from ch1 (pointer was 0), then hold it for three cycles
    b_if.in_data[63:32] = 32'hDEAD_BEEF;
    b_if.in_valid = 4'b0010;
    #1;
    check("st_b_rdy_pre", 32'(b_if.in_ready), 32'b0010);
    tick();
    check("st_b_load_vld",  32'(b_if.out_valid), 32'd1);
    check("st_b_load_data", b_if.out_data,       32'hDEAD_BEEF);
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_b_rdy", 32'(b_if.in_ready), 32'd0);
      tick();
      check("st_b_vld",  32'(b_if.out_valid), 32'd1);
      check("st_b_data", b_if.out_data,       32'hDEAD_BEEF);
      check("st_b_sel",  32'(b_if.out_sel),   32'd1);
    end
    // Pointer still at 1 after the stall, so ch2 is next
    b_if.out_ready = 1'b1;
    #1;
    check("st_b_rdy_post", 32'(b_if.in_ready), 32'b0100);
    tick();
    check("st_b_sel_post",  32'(b_if.out_sel), 32'd2);
    check("st_b_data_post", b_if.out_data,     32'hB000_0002);

    // Async reset between edges while a word is held
    b_if.out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("ar_b_vld",  32'(b_if.out_valid), 32'd0);
    check("ar_b_data", b_if.out_data,       32'd0);
    check("ar_b_sel",  32'(b_if.out_sel),   32'd0);
    check("ar_a_vld",  32'(a_if.out_valid), 32'd0);
    check("ar_b_rdy",  32'(b_if.in_ready),  32'd0);
    #1;
    reset = 1'b1;
    b_if.out_ready = 1'b1;
    #1;
    check("ar_b_rdy_rel", 32'(b_if.in_ready), 32'b0001);
    check("ar_a_rdy_rel", 32'(a_if.in_ready), 32'b0010);
    tick();
    check("ar_b_vld_post", 32'(b_if.out_valid), 32'd1);
    check("ar_b_sel_post", 32'(b_if.out_sel),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
